// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: credit-limited in-order instruction memory reads,
// a PC-tagged instruction FIFO, and redirect with stale-response dropping.
module instr_fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [31:0]     i_imem_rsp_data,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_instr_valid,
  input  logic            i_instr_ready,
  output logic [31:0]     o_instr_data,
  output logic [XLEN-1:0] o_instr_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned IW = 32;

  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] rsp_pc, rsp_pc_nxt;
  logic [CW-1:0]   inflight, inflight_nxt;
  logic [CW-1:0]   drop_cnt, drop_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [AW-1:0]   rd_ptr, rd_nxt;
  logic [AW-1:0]   wr_ptr, wr_nxt;

  logic [IW-1:0]   fifo_data [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];

  logic [CW:0]     occupancy;
  logic            credit_ok;
  logic            req_fire;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic [XLEN-1:0] redirect_pc_aligned;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Every outstanding request owns a FIFO slot, so responses never need backpressure.
  assign occupancy           = {1'b0, inflight} + {1'b0, count};
  assign credit_ok           = occupancy < (CW+1)'(FIFO_DEPTH);
  assign o_imem_req_valid    = !rst && !i_redirect_valid && credit_ok;
  assign o_imem_req_addr     = pc;
  assign req_fire            = o_imem_req_valid && i_imem_req_ready;
  assign fifo_empty          = (count == '0);
  assign o_instr_valid       = !fifo_empty && !i_redirect_valid;
  assign o_instr_data        = fifo_empty ? '0 : fifo_data[rd_ptr];
  assign o_instr_pc          = fifo_empty ? '0 : fifo_pc[rd_ptr];
  assign pop                 = o_instr_valid && i_instr_ready;
  assign push                = i_imem_rsp_valid && !i_redirect_valid && (drop_cnt == '0);
  assign redirect_pc_aligned = i_redirect_pc & ~XLEN'(3);

  // Next-state: redirect overrides everything except response accounting.
  always_comb begin
    pc_nxt       = pc;
    rsp_pc_nxt   = rsp_pc;
    inflight_nxt = inflight;
    drop_nxt     = drop_cnt;
    count_nxt    = count;
    rd_nxt       = rd_ptr;
    wr_nxt       = wr_ptr;
    if (i_redirect_valid) begin
      pc_nxt     = redirect_pc_aligned;
      rsp_pc_nxt = redirect_pc_aligned;
      if (i_imem_rsp_valid) begin
        inflight_nxt = inflight - CW'(1);
      end
      drop_nxt  = inflight_nxt;
      count_nxt = '0;
      rd_nxt    = '0;
      wr_nxt    = '0;
    end else begin
      if (req_fire) begin
        pc_nxt = pc + XLEN'(4);
      end
      if (req_fire && !i_imem_rsp_valid) begin
        inflight_nxt = inflight + CW'(1);
      end else if (!req_fire && i_imem_rsp_valid) begin
        inflight_nxt = inflight - CW'(1);
      end
      if (i_imem_rsp_valid && (drop_cnt != '0)) begin
        drop_nxt = drop_cnt - CW'(1);
      end
      if (push) begin
        rsp_pc_nxt = rsp_pc + XLEN'(4);
        wr_nxt     = ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_nxt = ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count_nxt = count + CW'(1);
      end else if (!push && pop) begin
        count_nxt = count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      pc       <= pc_nxt;
      rsp_pc   <= rsp_pc_nxt;
      inflight <= inflight_nxt;
      drop_cnt <= drop_nxt;
      count    <= count_nxt;
      rd_ptr   <= rd_nxt;
      wr_ptr   <= wr_nxt;
    end
  end

  // Storage needs no reset: the head is only visible while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_data[wr_ptr] <= i_imem_rsp_data;
      fifo_pc[wr_ptr]   <= rsp_pc;
    end
  end

`ifndef SYNTHESIS
  a_rsp_without_req: assert property (@(posedge clk) disable iff (rst)
    !(i_imem_rsp_valid && (inflight == '0)))
    else $error("imem response with no request in flight");
  a_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == CW'(FIFO_DEPTH))))
    else $error("instruction FIFO push while full");
  a_reset_pc_aligned: assert property (@(posedge clk) RESET_PC[1:0] == 2'b00)
    else $error("RESET_PC is not word aligned");
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end fetch stage. Feeds the instruction decoder through a valid/ready instruction stream.
- Owns the program counter (PC) and issues in-order word reads to instruction memory.
- Buffers returned words in a small FIFO and tags each word with its PC.
- Supports a PC redirect for branch/jump/trap: flushes buffered words and discards stale in-flight responses.

Parameters:
XLEN, 32, address/PC width
RESET_PC, 0, PC loaded on reset (bits [1:0] must be 0)
FIFO_DEPTH, 4, instruction buffer entries; also the credit limit for requests (>=2; >=3 for full throughput)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
o_imem_req_valid  output  1  fetch request valid
i_imem_req_ready  input  1  memory accepts request
o_imem_req_addr  output  XLEN  word-aligned fetch address
i_imem_rsp_valid  input  1  read data valid; in order, no backpressure, >=1 cycle after acceptance
i_imem_rsp_data  input  32  instruction word
i_redirect_valid  input  1  single-cycle PC redirect
i_redirect_pc  input  XLEN  new PC; bits [1:0] ignored (treated as 0)
o_instr_valid  output  1  instruction available to decoder
i_instr_ready  input  1  decoder accepts instruction
o_instr_data  output  32  instruction word
o_instr_pc  output  XLEN  PC of o_instr_data

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_PC, FIFO empty, inflight=0, drop_cnt=0. Outputs are o_imem_req_valid=0, o_instr_valid=0, o_instr_data=0, o_instr_pc=0. Reset mid-operation abandons everything. Responses for pre-reset requests must not arrive after reset; memory is reset on the same rst.
- Credit rule: o_imem_req_valid = !rst && !i_redirect_valid && (inflight + fifo_count < FIFO_DEPTH).
  - inflight counts accepted requests whose response has not yet returned, including stale ones.
  - Because the response channel has no ready, every response is guaranteed a slot.
- Request: o_imem_req_addr = pc.
  - On req handshake: pc <= pc + 4 (mod 2^XLEN, wraps to 0) and inflight++.
  - While not accepted and with no redirect, the address is held stable.
- Response: inflight--.
  - If drop_cnt > 0: discard the word and decrement drop_cnt.
  - Otherwise push {data, rsp_pc} into the FIFO, where rsp_pc is an internal PC that tracks the expected response address (+4 per kept response).
  - Simultaneous request and response in one cycle: inflight unchanged.
- Output: FIFO head is registered; no bypass.
  - o_instr_valid = !fifo_empty && !i_redirect_valid.
  - On an output handshake, pop. Data and PC stay stable while valid && !ready.
  - Simultaneous push and pop on a full FIFO is not reachable because of the credit rule.
  - Push and pop on a non-empty FIFO in one cycle: count unchanged.
- Latency, memory ready with 1-cycle response:
  - First request issued in the first cycle after rst deasserts (T0).
  - Response at T1; o_instr_valid at T2.
  - Steady-state 1 instr/cycle when FIFO_DEPTH>=3 and decoder always ready. FIFO_DEPTH=2 gives 2 instrs per 3 cycles.
- Redirect (i_redirect_valid=1 in cycle R). At the R edge:
  - pc <= {i_redirect_pc[XLEN-1:2], 2'b00}; rsp_pc <= same.
  - FIFO flushed.
  - drop_cnt <= inflight after this cycle's accounting: all outstanding requests become stale. A response arriving in cycle R is discarded and not counted.
  - In cycle R, o_imem_req_valid=0 and o_instr_valid=0, so no handshakes occur in R.
  - First request to the new PC in R+1 if credits allow.
  - Back-to-back redirects: the last one wins. drop_cnt is recomputed each time and covers everything still inflight.
- Boundaries:
  - FIFO full with decoder stalled: no requests issued; pc frozen.
  - Memory never ready: valid held high, pc frozen.
  - Counters never exceed FIFO_DEPTH; widths are clog2(FIFO_DEPTH+1).
- Assertions (sim only):
  - response arriving with inflight==0;
  - FIFO push when full;
  - RESET_PC[1:0]!=0.

Test Plan:
- Reset release, memory always ready, 1-cycle response, decoder always ready -> requests to 0x0,0x4,0x8,... on consecutive cycles; first o_instr_valid 2 cycles after first request with o_instr_pc=0x0; 1 instr/cycle thereafter.
- Decoder ready=0 for 10 cycles -> FIFO fills to 4, o_imem_req_valid drops with pc=0x10; on ready=1 words pop in order 0x0..0xC with no loss or duplication.
- Memory ready=0 for 5 cycles -> o_imem_req_addr held at the same value, no pc advance; resumes correctly.
- Two requests in flight (0x8, 0xC, 3-cycle response latency), redirect to 0x100 -> both stale responses discarded; next o_instr_valid has o_instr_pc=0x100 with data from 0x100.
- Redirect to 0x203 in the same cycle as a response arrival and o_instr_valid=1, i_instr_ready=1 -> no output handshake that cycle; response dropped; next fetch address 0x200.
- RESET_PC=0xFFFFFFFC -> fetch 0xFFFFFFFC, then 0x00000000; o_instr_pc sequence matches.
